// File: rtl/arr_nibble_tx.sv
// ---------------------------------------------------------------------------
// arr_nibble_tx
//
// Purpose:
//   Captures a packed two-dimensional array of nibbles in one handshake and
//   sends it as a stream of single-nibble beats. The leftmost element goes
//   first, so beat 0 is in_data[OUTER-1][MID-1]. Only one array is in flight
//   at a time. After the final beat there is one idle cycle before the next
//   array can be captured.
//
// Optional feature:
//   `define ARR_TX_PARITY_EN adds one trailing beat. Its data is the XOR of
//   all captured nibbles, and its index is OUTER*MID. With the macro
//   undefined, the array ends on beat OUTER*MID-1.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   source offers an array
//   in_ready   block is idle and can capture an array
//   in_data    [OUTER-1:0][MID-1:0][NIB_W-1:0] array to send
//   out_valid  out_data holds a valid beat
//   out_ready  sink accepts the beat
//   out_data   current nibble (0 while out_valid is low)
//   out_last   current beat is the final beat of the array
//   out_idx    beat index within the array, 0 first
//   busy       array captured and not yet fully sent
// ---------------------------------------------------------------------------
module arr_nibble_tx #(
    parameter int OUTER = 2,
    parameter int MID   = 2,
    parameter int NIB_W = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [OUTER-1:0][MID-1:0][NIB_W-1:0]  in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NIB_W-1:0]                      out_data,
    output logic                                  out_last,
    output logic [$clog2(OUTER*MID+1)-1:0]        out_idx,
    output logic                                  busy
);

    localparam int BEATS = OUTER * MID;
    localparam int IDX_W = $clog2(BEATS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

`ifdef ARR_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t                               state;
    state_t                               next_state;
    logic [OUTER-1:0][MID-1:0][NIB_W-1:0] cap;
    logic [IDX_W-1:0]                     idx;
    logic [NIB_W-1:0]                     beat_nib;
`ifdef ARR_TX_PARITY_EN
    logic [NIB_W-1:0]                     par_nib;
`endif

    // State register. Reset drops any array in flight straight back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. out_valid is high in every non-idle state, so a beat
    // transfers whenever out_ready is high there.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (out_ready && (idx == LAST_IDX)) begin
`ifdef ARR_TX_PARITY_EN
                    next_state = PAR;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef ARR_TX_PARITY_EN
            PAR: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Capture register and beat counter.
    // The array is snapshotted on capture, so input changes during sending
    // cannot disturb the beats already in flight.
    // The index returns to 0 after the array finishes, so out_idx is 0
    // whenever the block is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap <= in_data;
                        idx <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
`ifdef ARR_TX_PARITY_EN
                        idx <= idx + IDX_W'(1);
`else
                        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
`endif
                    end
                end
`ifdef ARR_TX_PARITY_EN
                PAR: begin
                    if (out_ready) begin
                        idx <= '0;
                    end
                end
`endif
                default: idx <= '0;
            endcase
        end
    end

    // Beat k selects the element k places from the leftmost one, walking the
    // inner (nibble) dimension fastest.
    always_comb begin
        beat_nib = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == IDX_W'(k)) begin
                beat_nib = cap[OUTER-1-k/MID][MID-1-k%MID];
            end
        end
    end

`ifdef ARR_TX_PARITY_EN
    // Running XOR across every captured nibble, used by the trailing beat.
    always_comb begin
        par_nib = '0;
        for (int o = 0; o < OUTER; o++) begin
            for (int m = 0; m < MID; m++) begin
                par_nib = par_nib ^ cap[o][m];
            end
        end
    end
`endif

    // Output decode. Data and last are forced to 0 whenever no beat is
    // valid, so the idle bus is quiet.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state != IDLE);
        out_idx   = idx;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            SEND: begin
                out_data = beat_nib;
`ifndef ARR_TX_PARITY_EN
                out_last = (idx == LAST_IDX);
`endif
            end
`ifdef ARR_TX_PARITY_EN
            PAR: begin
                out_data = par_nib;
                out_last = 1'b1;
            end
`endif
            default: begin
                out_data = '0;
                out_last = 1'b0;
            end
        endcase
    end

endmodule
